writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The module SHALL have parameter TAG_DEPTH, default 4, giving the depth of the outstanding-load tag FIFO (power of 2, 2..16).
REQ-002 The port clk SHALL be an input, 1 bit wide, and act as the single clock, rising-edge active.
REQ-003 The port rst_n SHALL be an input, 1 bit wide, and act as the reset, asynchronous and active-low.
REQ-004 The ports alu_valid (in, 1), alu_dest (in, 5) and alu_data (in, 32) SHALL carry an ALU result write request.
REQ-005 The port alu_ready SHALL be an output, 1 bit wide, and indicate that the ALU request is accepted this cycle.
REQ-006 The ports link_valid (in, 1), link_dest (in, 5) and link_addr (in, 32) SHALL carry a PC-link write request.
REQ-007 The port link_ready SHALL be an output, 1 bit wide, and indicate that the link request is accepted this cycle.
REQ-008 The ports load_issue (in, 1) and load_dest (in, 5) SHALL indicate that a load has been issued and give its destination register.
REQ-009 The port load_ready SHALL be an output, 1 bit wide, and indicate that the load issue is accepted this cycle.
REQ-010 The ports mem_valid (in, 1) and mem_data (in, 32) SHALL carry an in-order load response; these ports have no back-pressure.
REQ-011 The register-file drive ports SHALL be outputs: rf_write_enable (1), rf_dest (5), rf_alu_data (32), rf_memory_in (32), rf_pc_addr (32), rf_mem_data_in (1) and rf_pc_next_enable (1).
REQ-012 The port busy SHALL be an output, 32 bits wide, where bit r set means register r has a load outstanding.
REQ-013 The port tag_error SHALL be an output, 1 bit wide, and be a sticky flag for a memory response arriving with no tag outstanding.
REQ-014 The ports fwd_valid (out, 1), fwd_dest (out, 5) and fwd_data (out, 32) SHALL be the forwarding outputs defined in Configuration.

Function
REQ-015 The arbitration priority SHALL be mem > link > alu; exactly one write is accepted per cycle.
REQ-016 Ready logic SHALL be: link_ready = !mem_valid; alu_ready = !mem_valid && !link_valid; both are combinational.
REQ-017 Accepting a mem response SHALL pop the head tag, and the write SHALL use dest = popped tag and data = mem_data.
REQ-018 Drive outputs SHALL be registered, so that a request accepted in cycle N appears on the rf_* outputs in cycle N+1 for exactly one cycle.
REQ-019 The select flags SHALL be: mem write -> rf_mem_data_in=1, rf_pc_next_enable=0; link write -> 0,1; alu write -> 0,0.
REQ-020 Data outputs not selected SHALL hold their previous value.
REQ-021 In a cycle with no accepted write, rf_write_enable SHALL be 0.
REQ-022 load_ready SHALL be computed as !tag_full && !busy[load_dest] && !(mem_valid && tag_count==0).
REQ-023 An accepted load issue SHALL push load_dest into the tag FIFO and set busy[load_dest].
REQ-024 busy[tag] SHALL clear on the same clock edge that the mem response for that tag is accepted.
REQ-025 When load_issue and mem_valid occur in the same cycle, the push and pop SHALL both occur and tag_count SHALL be unchanged.
REQ-026 An issue to a register freed in the same cycle SHALL be refused, because the busy check uses the pre-edge value.
REQ-027 When mem_valid occurs with tag_count==0, the response SHALL be dropped, tag_error SHALL be set, and no write SHALL occur.
REQ-028 The tag FIFO read and write pointers SHALL wrap modulo TAG_DEPTH, and the full/empty decision SHALL use a count of width clog2(TAG_DEPTH)+1.
REQ-029 No special treatment SHALL be given to register 0; writes to dest 0 are issued like any other.

Reset
REQ-030 While rst_n=0, the outputs SHALL be: rf_write_enable=0, rf_dest=0, all rf data outputs=0, both select flags=0, busy=0, tag_error=0, fwd_valid=0.
REQ-031 While rst_n=0, the tag FIFO SHALL be empty with both pointers at 0.
REQ-032 Reset mid-operation SHALL discard all outstanding tags; responses arriving after reset release set tag_error.

Configuration
REQ-033 With WB_FORWARD_EN defined, fwd_valid/fwd_dest/fwd_data SHALL combinationally mirror rf_write_enable/rf_dest and the selected data of the current rf_* outputs.
REQ-034 Without WB_FORWARD_EN, fwd_valid, fwd_dest and fwd_data SHALL be tied to 0 and no forwarding logic SHALL be present.

Verification
REQ-035 Bench SHALL drive alu_valid, dest=3, data=0xDEADBEEF with idle mem/link -> alu_ready=1; next cycle rf_write_enable=1, rf_dest=3, rf_alu_data=0xDEADBEEF, both selects 0.
REQ-036 Bench SHALL drive alu_valid, link_valid and mem_valid together with tag 7 pending -> only mem accepted (dest 7); alu_ready=0, link_ready=0; busy[7] clears.
REQ-037 Bench SHALL issue loads to 1,2,3,4 (TAG_DEPTH=4) -> load_ready=0 on a fifth issue; responses 0xA..0xD write to dest 1..4 in order; busy returns to 0.
REQ-038 Bench SHALL issue a load to 5 and then, with busy[5]=1, issue a second load to 5 -> load_ready=0; a simultaneous issue to 6 with a response popping 5 -> tag_count unchanged, busy=bit6.
REQ-039 Bench SHALL drive mem_valid with no tags -> tag_error=1 and rf_write_enable=0; asserting rst_n=0 mid-burst with 2 tags outstanding -> busy=0 and the FIFO empty.
REQ-040 Bench SHALL, with WB_FORWARD_EN defined and a link write of 0x100 to dest 31 -> fwd_valid=1, fwd_dest=31, fwd_data=0x100 in the write cycle; without the macro -> fwd_* = 0.

Source files
------------

// File: rtl/writeback_unit_if.sv
// Writeback unit bus: ALU/link/load requests, memory responses, register-file drive and status.
// Ports: slave = writeback unit view, master = producer/bench view.
// Latency/backpressure: carried by the signals; readies are combinational in the unit.
interface writeback_unit_if;
    logic        alu_valid;
    logic [4:0]  alu_dest;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        link_valid;
    logic [4:0]  link_dest;
    logic [31:0] link_addr;
    logic        link_ready;
    logic        load_issue;
    logic [4:0]  load_dest;
    logic        load_ready;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        rf_write_enable;
    logic [4:0]  rf_dest;
    logic [31:0] rf_alu_data;
    logic [31:0] rf_memory_in;
    logic [31:0] rf_pc_addr;
    logic        rf_mem_data_in;
    logic        rf_pc_next_enable;
    logic [31:0] busy;
    logic        tag_error;
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;

    modport slave (
        input  alu_valid, alu_dest, alu_data, link_valid, link_dest, link_addr,
               load_issue, load_dest, mem_valid, mem_data,
        output alu_ready, link_ready, load_ready,
               rf_write_enable, rf_dest, rf_alu_data, rf_memory_in, rf_pc_addr,
               rf_mem_data_in, rf_pc_next_enable, busy, tag_error,
               fwd_valid, fwd_dest, fwd_data
    );

    modport master (
        output alu_valid, alu_dest, alu_data, link_valid, link_dest, link_addr,
               load_issue, load_dest, mem_valid, mem_data,
        input  alu_ready, link_ready, load_ready,
               rf_write_enable, rf_dest, rf_alu_data, rf_memory_in, rf_pc_addr,
               rf_mem_data_in, rf_pc_next_enable, busy, tag_error,
               fwd_valid, fwd_dest, fwd_data
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback arbiter (mem > link > alu) with in-order load tag FIFO and per-register busy scoreboard.
// Latency: accepted request drives rf_* one cycle later for one cycle; optional WB_FORWARD_EN mirrors it on fwd_*.
// Backpressure: link/alu ready combinationally from higher-priority valids; mem has none; loads refused when full/busy.
// Ports: clk, rst_n (async active-low), bus (writeback_unit_if.slave).
module writeback_unit #(
    parameter int TAG_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    writeback_unit_if.slave    bus
);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = $clog2(TAG_DEPTH) + 1;

    logic [4:0]    tag_mem [TAG_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] tag_count;
    logic [31:0]   busy_q;
    logic          tag_error_q;

    logic          we_q;
    logic [4:0]    dest_q;
    logic [31:0]   alu_data_q;
    logic [31:0]   mem_data_q;
    logic [31:0]   pc_addr_q;
    logic          mem_sel_q;
    logic          pc_sel_q;

    logic          tag_empty;
    logic          tag_full;
    logic [4:0]    head_tag;
    logic          mem_acc;
    logic          link_acc;
    logic          alu_acc;
    logic          load_rdy;
    logic          load_acc;

    assign tag_empty = (tag_count == '0);
    assign tag_full  = (tag_count == CW'(TAG_DEPTH));
    assign head_tag  = tag_mem[rd_ptr];

    // A response with no tag is dropped but still blocks link/alu for the cycle.
    assign mem_acc  = bus.mem_valid && !tag_empty;
    assign link_acc = bus.link_valid && !bus.mem_valid;
    assign alu_acc  = bus.alu_valid && !bus.mem_valid && !bus.link_valid;

    // Busy check uses the pre-edge scoreboard, so a register freed this cycle is still refused.
    assign load_rdy = !tag_full && !busy_q[bus.load_dest] && !(bus.mem_valid && tag_empty);
    assign load_acc = bus.load_issue && load_rdy;

    always_ff @(posedge clk) begin
        if (load_acc) begin
            tag_mem[wr_ptr] <= bus.load_dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_count   <= '0;
            busy_q      <= '0;
            tag_error_q <= 1'b0;
        end else begin
            if (load_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (mem_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({load_acc, mem_acc})
                2'b10:   tag_count <= tag_count + 1'b1;
                2'b01:   tag_count <= tag_count - 1'b1;
                default: tag_count <= tag_count;
            endcase
            // Set and clear never hit the same bit: an issue to a busy register is refused.
            busy_q <= (busy_q & ~(mem_acc ? (32'd1 << head_tag) : 32'd0))
                             |  (load_acc ? (32'd1 << bus.load_dest) : 32'd0);
            if (bus.mem_valid && tag_empty) begin
                tag_error_q <= 1'b1;
            end
        end
    end

    // Register-file drive; unselected data registers keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            dest_q     <= '0;
            alu_data_q <= '0;
            mem_data_q <= '0;
            pc_addr_q  <= '0;
            mem_sel_q  <= 1'b0;
            pc_sel_q   <= 1'b0;
        end else begin
            we_q      <= mem_acc || link_acc || alu_acc;
            mem_sel_q <= 1'b0;
            pc_sel_q  <= 1'b0;
            if (mem_acc) begin
                dest_q     <= head_tag;
                mem_data_q <= bus.mem_data;
                mem_sel_q  <= 1'b1;
            end else if (link_acc) begin
                dest_q    <= bus.link_dest;
                pc_addr_q <= bus.link_addr;
                pc_sel_q  <= 1'b1;
            end else if (alu_acc) begin
                dest_q     <= bus.alu_dest;
                alu_data_q <= bus.alu_data;
            end
        end
    end

    assign bus.alu_ready         = !bus.mem_valid && !bus.link_valid;
    assign bus.link_ready        = !bus.mem_valid;
    assign bus.load_ready        = load_rdy;
    assign bus.rf_write_enable   = we_q;
    assign bus.rf_dest           = dest_q;
    assign bus.rf_alu_data       = alu_data_q;
    assign bus.rf_memory_in      = mem_data_q;
    assign bus.rf_pc_addr        = pc_addr_q;
    assign bus.rf_mem_data_in    = mem_sel_q;
    assign bus.rf_pc_next_enable = pc_sel_q;
    assign bus.busy              = busy_q;
    assign bus.tag_error         = tag_error_q;

`ifdef WB_FORWARD_EN
    assign bus.fwd_valid = we_q;
    assign bus.fwd_dest  = dest_q;
    assign bus.fwd_data  = mem_sel_q ? mem_data_q : (pc_sel_q ? pc_addr_q : alu_data_q);
`else
    assign bus.fwd_valid = 1'b0;
    assign bus.fwd_dest  = '0;
    assign bus.fwd_data  = '0;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: reset, ALU/link/mem writes, priority, tag FIFO full,
// same-register issue, tag errors, mid-run reset, and forwarding (build-dependent).
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
module tb_writeback_unit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    writeback_unit_if bus();

    writeback_unit #(.TAG_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid  = 1'b0; bus.alu_dest  = '0; bus.alu_data  = '0;
        bus.link_valid = 1'b0; bus.link_dest = '0; bus.link_addr = '0;
        bus.load_issue = 1'b0; bus.load_dest = '0;
        bus.mem_valid  = 1'b0; bus.mem_data  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        go(); go();
        n_cmp++; if (bus.rf_write_enable !== 1'b0) begin n_bad++; $display("FAIL rst_we got %b want 0", bus.rf_write_enable); end
        n_cmp++; if (bus.rf_dest !== 5'd0) begin n_bad++; $display("FAIL rst_dest got %0d want 0", bus.rf_dest); end
        n_cmp++; if ({bus.rf_alu_data, bus.rf_memory_in, bus.rf_pc_addr} !== 96'd0) begin n_bad++; $display("FAIL rst_data got %h %h %h want 0", bus.rf_alu_data, bus.rf_memory_in, bus.rf_pc_addr); end
        n_cmp++; if ({bus.rf_mem_data_in, bus.rf_pc_next_enable} !== 2'b00) begin n_bad++; $display("FAIL rst_sel got %b%b want 00", bus.rf_mem_data_in, bus.rf_pc_next_enable); end
        n_cmp++; if (bus.busy !== 32'd0) begin n_bad++; $display("FAIL rst_busy got %h want 0", bus.busy); end
        n_cmp++; if ({bus.tag_error, bus.fwd_valid} !== 2'b00) begin n_bad++; $display("FAIL rst_err_fwd got %b%b want 00", bus.tag_error, bus.fwd_valid); end
        n_cmp++; if ({dut.tag_count, dut.wr_ptr, dut.rd_ptr} !== 7'd0) begin n_bad++; $display("FAIL rst_fifo got cnt=%0d wr=%0d rd=%0d want 0", dut.tag_count, dut.wr_ptr, dut.rd_ptr); end
        rst_n = 1'b1;
        go();
    endtask

    task automatic test_alu();
        bus.alu_valid = 1'b1; bus.alu_dest = 5'd3; bus.alu_data = 32'hDEADBEEF;
        #1;
        n_cmp++; if (bus.alu_ready !== 1'b1) begin n_bad++; $display("FAIL alu_ready got %b want 1", bus.alu_ready); end
        go();
        bus.alu_valid = 1'b0;
        n_cmp++; if (bus.rf_write_enable !== 1'b1 || bus.rf_dest !== 5'd3) begin n_bad++; $display("FAIL alu_we_dest got %b/%0d want 1/3", bus.rf_write_enable, bus.rf_dest); end
        n_cmp++; if (bus.rf_alu_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL alu_data got %h want deadbeef", bus.rf_alu_data); end
        n_cmp++; if ({bus.rf_mem_data_in, bus.rf_pc_next_enable} !== 2'b00) begin n_bad++; $display("FAIL alu_sel got %b%b want 00", bus.rf_mem_data_in, bus.rf_pc_next_enable); end
`ifdef WB_FORWARD_EN
        n_cmp++; if (bus.fwd_valid !== 1'b1 || bus.fwd_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL alu_fwd got %b/%h want 1/deadbeef", bus.fwd_valid, bus.fwd_data); end
`endif
        go();
        n_cmp++; if (bus.rf_write_enable !== 1'b0 || bus.rf_alu_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL alu_one_cycle got %b/%h want 0/deadbeef", bus.rf_write_enable, bus.rf_alu_data); end
    endtask

    task automatic test_priority();
        bus.load_issue = 1'b1; bus.load_dest = 5'd7;
        #1;
        n_cmp++; if (bus.load_ready !== 1'b1) begin n_bad++; $display("FAIL pri_load_ready got %b want 1", bus.load_ready); end
        go();
        bus.load_issue = 1'b0;
        n_cmp++; if (bus.busy !== 32'h0000_0080) begin n_bad++; $display("FAIL pri_busy7 got %h want 00000080", bus.busy); end
        bus.alu_valid = 1'b1;  bus.alu_dest = 5'd1;   bus.alu_data = 32'h1111;
        bus.link_valid = 1'b1; bus.link_dest = 5'd2;  bus.link_addr = 32'h2222;
        bus.mem_valid = 1'b1;  bus.mem_data = 32'h77;
        #1;
        n_cmp++; if ({bus.alu_ready, bus.link_ready} !== 2'b00) begin n_bad++; $display("FAIL pri_readies got %b%b want 00", bus.alu_ready, bus.link_ready); end
        go();
        idle_inputs();
        n_cmp++; if (bus.rf_write_enable !== 1'b1 || bus.rf_dest !== 5'd7 || bus.rf_memory_in !== 32'h77) begin n_bad++; $display("FAIL pri_mem_write got %b/%0d/%h want 1/7/77", bus.rf_write_enable, bus.rf_dest, bus.rf_memory_in); end
        n_cmp++; if ({bus.rf_mem_data_in, bus.rf_pc_next_enable} !== 2'b10) begin n_bad++; $display("FAIL pri_sel got %b%b want 10", bus.rf_mem_data_in, bus.rf_pc_next_enable); end
        n_cmp++; if (bus.busy !== 32'd0) begin n_bad++; $display("FAIL pri_busy_clear got %h want 0", bus.busy); end
        n_cmp++; if (bus.rf_alu_data !== 32'hDEADBEEF || bus.rf_pc_addr !== 32'd0) begin n_bad++; $display("FAIL pri_hold got %h/%h want deadbeef/0", bus.rf_alu_data, bus.rf_pc_addr); end
        go();
    endtask

    task automatic test_link_fwd();
        bus.link_valid = 1'b1; bus.link_dest = 5'd31; bus.link_addr = 32'h100;
        bus.alu_valid = 1'b1; bus.alu_dest = 5'd9; bus.alu_data = 32'h9999;
        #1;
        n_cmp++; if ({bus.link_ready, bus.alu_ready} !== 2'b10) begin n_bad++; $display("FAIL link_readies got %b%b want 10", bus.link_ready, bus.alu_ready); end
        go();
        idle_inputs();
        n_cmp++; if (bus.rf_write_enable !== 1'b1 || bus.rf_dest !== 5'd31 || bus.rf_pc_addr !== 32'h100) begin n_bad++; $display("FAIL link_write got %b/%0d/%h want 1/31/100", bus.rf_write_enable, bus.rf_dest, bus.rf_pc_addr); end
        n_cmp++; if ({bus.rf_mem_data_in, bus.rf_pc_next_enable} !== 2'b01) begin n_bad++; $display("FAIL link_sel got %b%b want 01", bus.rf_mem_data_in, bus.rf_pc_next_enable); end
`ifdef WB_FORWARD_EN
        n_cmp++; if (bus.fwd_valid !== 1'b1 || bus.fwd_dest !== 5'd31 || bus.fwd_data !== 32'h100) begin n_bad++; $display("FAIL link_fwd got %b/%0d/%h want 1/31/100", bus.fwd_valid, bus.fwd_dest, bus.fwd_data); end
`else
        n_cmp++; if (bus.fwd_valid !== 1'b0 || bus.fwd_dest !== 5'd0 || bus.fwd_data !== 32'd0) begin n_bad++; $display("FAIL link_fwd_off got %b/%0d/%h want 0/0/0", bus.fwd_valid, bus.fwd_dest, bus.fwd_data); end
`endif
        go();
    endtask

    task automatic test_fifo_full();
        for (int d = 1; d <= 4; d++) begin
            bus.load_issue = 1'b1; bus.load_dest = 5'(d);
            go();
        end
        bus.load_dest = 5'd5;
        #1;
        n_cmp++; if (bus.load_ready !== 1'b0) begin n_bad++; $display("FAIL full_load_ready got %b want 0", bus.load_ready); end
        n_cmp++; if (bus.busy !== 32'h0000_001E || dut.tag_count !== 3'd4) begin n_bad++; $display("FAIL full_busy got %h cnt=%0d want 0000001e cnt=4", bus.busy, dut.tag_count); end
        bus.load_issue = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_valid = 1'b1; bus.mem_data = 32'hA + 32'(i);
            go();
            n_cmp++; if (bus.rf_write_enable !== 1'b1 || bus.rf_dest !== 5'(i + 1) || bus.rf_memory_in !== 32'hA + 32'(i)) begin n_bad++; $display("FAIL full_resp%0d got %b/%0d/%h want 1/%0d/%h", i, bus.rf_write_enable, bus.rf_dest, bus.rf_memory_in, i + 1, 32'hA + 32'(i)); end
        end
        bus.mem_valid = 1'b0;
        n_cmp++; if (bus.busy !== 32'd0 || dut.tag_count !== 3'd0) begin n_bad++; $display("FAIL full_drain got %h cnt=%0d want 0 cnt=0", bus.busy, dut.tag_count); end
        go();
    endtask

    task automatic test_same_reg();
        bus.load_issue = 1'b1; bus.load_dest = 5'd5;
        go();
        #1;
        n_cmp++; if (bus.load_ready !== 1'b0) begin n_bad++; $display("FAIL same_busy_refuse got %b want 0", bus.load_ready); end
        bus.load_dest = 5'd6; bus.mem_valid = 1'b1; bus.mem_data = 32'h55;
        #1;
        n_cmp++; if (bus.load_ready !== 1'b1) begin n_bad++; $display("FAIL same_pushpop_ready got %b want 1", bus.load_ready); end
        go();
        bus.load_issue = 1'b0; bus.mem_valid = 1'b0;
        n_cmp++; if (dut.tag_count !== 3'd1 || bus.busy !== 32'h0000_0040) begin n_bad++; $display("FAIL same_pushpop got cnt=%0d busy=%h want 1/00000040", dut.tag_count, bus.busy); end
        n_cmp++; if (bus.rf_dest !== 5'd5 || bus.rf_memory_in !== 32'h55) begin n_bad++; $display("FAIL same_resp5 got %0d/%h want 5/55", bus.rf_dest, bus.rf_memory_in); end
        // Issue to 6 while its response is being accepted: still refused.
        bus.load_issue = 1'b1; bus.load_dest = 5'd6; bus.mem_valid = 1'b1; bus.mem_data = 32'h66;
        #1;
        n_cmp++; if (bus.load_ready !== 1'b0) begin n_bad++; $display("FAIL same_freed_refuse got %b want 0", bus.load_ready); end
        go();
        idle_inputs();
        n_cmp++; if (dut.tag_count !== 3'd0 || bus.busy !== 32'd0 || bus.rf_dest !== 5'd6) begin n_bad++; $display("FAIL same_drain got cnt=%0d busy=%h dest=%0d want 0/0/6", dut.tag_count, bus.busy, bus.rf_dest); end
        go();
    endtask

    task automatic test_tag_error();
        bus.mem_valid = 1'b1; bus.mem_data = 32'h99; bus.load_issue = 1'b1; bus.load_dest = 5'd10;
        #1;
        n_cmp++; if ({bus.link_ready, bus.load_ready} !== 2'b00) begin n_bad++; $display("FAIL err_readies got %b%b want 00", bus.link_ready, bus.load_ready); end
        go();
        idle_inputs();
        n_cmp++; if (bus.rf_write_enable !== 1'b0 || bus.tag_error !== 1'b1) begin n_bad++; $display("FAIL err_drop got we=%b err=%b want 0/1", bus.rf_write_enable, bus.tag_error); end
        go();
        n_cmp++; if (bus.tag_error !== 1'b1 || bus.busy !== 32'd0) begin n_bad++; $display("FAIL err_sticky got err=%b busy=%h want 1/0", bus.tag_error, bus.busy); end
    endtask

    task automatic test_reset_mid();
        bus.load_issue = 1'b1; bus.load_dest = 5'd8;
        go();
        bus.load_dest = 5'd9;
        go();
        bus.load_issue = 1'b0;
        n_cmp++; if (dut.tag_count !== 3'd2 || bus.busy !== 32'h0000_0300) begin n_bad++; $display("FAIL mid_pre got cnt=%0d busy=%h want 2/00000300", dut.tag_count, bus.busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 32'd0 || {dut.tag_count, dut.wr_ptr, dut.rd_ptr} !== 7'd0 || bus.tag_error !== 1'b0) begin n_bad++; $display("FAIL mid_rst got busy=%h cnt=%0d wr=%0d rd=%0d err=%b want 0", bus.busy, dut.tag_count, dut.wr_ptr, dut.rd_ptr, bus.tag_error); end
        go();
        rst_n = 1'b1;
        go();
        bus.mem_valid = 1'b1; bus.mem_data = 32'h88;
        go();
        bus.mem_valid = 1'b0;
        n_cmp++; if (bus.tag_error !== 1'b1 || bus.rf_write_enable !== 1'b0) begin n_bad++; $display("FAIL mid_post got err=%b we=%b want 1/0", bus.tag_error, bus.rf_write_enable); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_alu();
        test_priority();
        test_link_fwd();
        test_fifo_full();
        test_same_reg();
        test_tag_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
